irq_source_unit: RTL
====================

Name: irq_source_unit

Overview:
- Memory-mapped interrupt source block that drives the CPU core's 32-bit interrupt input. The core is the receiver of this interface; this block is the producer.
- Contains a machine timer (mtime/mtimecmp) that generates the timer interrupt, MTIP, on bit 7.
- Aggregates NUM_SRC edge-triggered external sources into the external interrupt, MEIP, on bit 11.
- Provides a claim register so the trap handler can identify and retire one source per read.

Parameters:
- NUM_SRC, 8, number of external interrupt sources (1..31).
- TIMER_WIDTH, 32, width of the mtime and mtimecmp counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- addr  in  5  word-aligned register offset; bits [1:0] are ignored.
- wdata  in  32  write data.
- wr_en  in  1  register write strobe, one cycle.
- rd_en  in  1  register read strobe, one cycle.
- rdata  out  32  read data, registered.
- ext_src  in  NUM_SRC  raw external interrupt lines, asynchronous to clk.
- interrupt_occured  out  32  interrupt vector to the core: bit 7 = MTIP, bit 11 = MEIP, all other bits 0.

Behaviour:
Register map (offsets):
- 0x00 MTIME: R/W.
- 0x04 MTIMECMP: R/W.
- 0x08 PENDING: R; write-1-to-clear.
- 0x0C ENABLE: R/W.
- 0x10 CLAIM: R with side effect; writes ignored.
- 0x14 CTRL: R/W; bit 0 = timer run, bit 1 = MTIE; other bits read 0.
- Any other offset reads 0; writes to it are ignored.
- Register fields are zero-extended to 32 bits on read. Unused upper bits of PENDING and ENABLE read 0.

Reset values (asynchronous, while reset = 0):
- mtime = 0, mtimecmp = all ones, pending = 0, enable = 0, ctrl = 0.
- Synchronizer flops = 0, edge-history flops = 0.
- rdata = 0, interrupt_occured = 0.

Timer:
- When ctrl[0] = 1, mtime increments by 1 every cycle and wraps from all ones to 0.
- A write to MTIME in the same cycle as an increment takes precedence; mtime = wdata on the next cycle.
- timer_hit = (mtime >= mtimecmp), unsigned comparison on the registered values.

External sources:
- Each ext_src bit passes through a 2-flop synchronizer, then a rising-edge detector (sync_q & ~prev_q).
- A detected edge sets pending[i].
- Write-1-to-clear: PENDING write clears every pending bit where wdata bit = 1.
- Set/clear priority: a set and a clear of the same bit in the same cycle leaves the bit set.
- Latency: 3 cycles from an ext_src rising edge to pending set (2 synchronizer stages + 1 edge/pending register).

CLAIM read:
- Returns id = i+1 for the lowest index i with pending[i] & enable[i] = 1; returns 0 if there is none.
- In the same cycle, clears pending[i] for that i.
- A new edge on the same source in that cycle keeps the bit set.
- A CLAIM read that returns 0 has no side effect.

Output vector:
- Registered; updated every cycle.
- interrupt_occured[7] = timer_hit & ctrl[1].
- interrupt_occured[11] = |(pending & enable).
- Latency: 1 cycle from the internal state change to the output.
- The output is level-sensitive and stays asserted until the cause is removed: mtimecmp rewritten above mtime, MTIE cleared, source claimed or cleared, or enable cleared.

Bus timing:
- rdata is valid on the cycle after rd_en and holds its value until the next read.
- Read and write in the same cycle to the same register: rdata returns the pre-write value; the write takes effect.
- Read-back of MTIME returns the value sampled in the rd_en cycle.

Reset mid-operation:
- All state returns immediately to reset values.
- Pending edges are lost.
- interrupt_occured drops to 0 asynchronously.

Test Plan:
- Reset release, no writes -> rdata = 0 and interrupt_occured = 0x0000_0000 for 100 cycles; reads of MTIMECMP = 0xFFFF_FFFF and CTRL = 0.
- Timer interrupt:
  - Stimulus: write MTIMECMP = 20, CTRL = 0x3 at cycle 0.
  - Required: interrupt_occured = 0x0000_0080 from the cycle after mtime reaches 20.
  - Then write MTIMECMP = 0xFFFF_FFFF -> bit 7 deasserts within 2 cycles.
- External edge and claim:
  - Stimulus: ENABLE = 0x0C; pulse ext_src[3] and ext_src[2] high in the same cycle.
  - Required: PENDING = 0x0C after 3 cycles; interrupt_occured = 0x0000_0800.
  - CLAIM read returns 3, then 4, then 0.
  - MEIP drops one cycle after the second claim.
- Masking and W1C:
  - Stimulus: ENABLE = 0; pulse ext_src[0].
  - Required: PENDING = 0x01 and interrupt_occured = 0.
  - Write PENDING = 0x01 -> PENDING = 0.
  - Set/clear collision: a new edge on source 0 arriving in the same cycle as the clear leaves PENDING = 0x01.
- Wrap and write precedence:
  - Stimulus: write MTIME = 0xFFFF_FFFE with CTRL = 0x1.
  - Required: MTIME reads 0xFFFF_FFFF, then 0x0000_0000 on consecutive cycles.
  - A write to MTIME in the same cycle as an increment yields exactly wdata.
- Mid-operation reset:
  - Stimulus: assert reset = 0 asynchronously while MEIP and MTIP are both high.
  - Required: interrupt_occured = 0 before the next clock edge; all registers at reset values after release.

Source files
------------

// File: rtl/irq_source_unit.sv
// Interrupt source block: machine timer (MTIP, bit 7) and edge-triggered external sources
// aggregated into MEIP (bit 11), with a memory-mapped register file and a claim register.
module irq_source_unit #(
  parameter int NUM_SRC     = 8,
  parameter int TIMER_WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         addr,
  input  logic [31:0]        wdata,
  input  logic               wr_en,
  input  logic               rd_en,
  output logic [31:0]        rdata,
  input  logic [NUM_SRC-1:0] ext_src,
  output logic [31:0]        interrupt_occured
);

  localparam logic [2:0] SEL_MTIME    = 3'd0;
  localparam logic [2:0] SEL_MTIMECMP = 3'd1;
  localparam logic [2:0] SEL_PENDING  = 3'd2;
  localparam logic [2:0] SEL_ENABLE   = 3'd3;
  localparam logic [2:0] SEL_CLAIM    = 3'd4;
  localparam logic [2:0] SEL_CTRL     = 3'd5;

  logic [TIMER_WIDTH-1:0] r_mtime;
  logic [TIMER_WIDTH-1:0] r_mtimecmp;
  logic [NUM_SRC-1:0]     r_pending;
  logic [NUM_SRC-1:0]     r_enable;
  logic [1:0]             r_ctrl;
  logic [NUM_SRC-1:0]     r_sync1;
  logic [NUM_SRC-1:0]     r_sync2;
  logic [NUM_SRC-1:0]     r_prev;
  logic [31:0]            r_rdata;
  logic                   r_mtip;
  logic                   r_meip;

  logic [2:0]             w_sel;
  logic                   w_wr_mtime;
  logic [NUM_SRC-1:0]     w_edge;
  logic [NUM_SRC-1:0]     w_active;
  logic [NUM_SRC-1:0]     w_claim_mask;
  logic [4:0]             w_claim_id;
  logic [NUM_SRC-1:0]     w_w1c;
  logic [NUM_SRC-1:0]     w_claim_clr;
  logic [31:0]            w_rdata_next;
  logic                   w_timer_hit;
  logic                   w_unused;

  assign w_sel      = addr[4:2];
  assign w_unused   = ^addr[1:0];
  assign w_wr_mtime = wr_en && (w_sel == SEL_MTIME);
  assign w_edge     = r_sync2 & ~r_prev;
  assign w_active   = r_pending & r_enable;
  // Isolate the lowest set bit: that source is the one a claim retires.
  assign w_claim_mask = w_active & (~w_active + {{(NUM_SRC-1){1'b0}}, 1'b1});
  assign w_timer_hit  = (r_mtime >= r_mtimecmp);

  always_comb begin
    w_claim_id = 5'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_active[i]) w_claim_id = 5'(i + 1);
    end
  end

  assign w_w1c       = (wr_en && (w_sel == SEL_PENDING)) ? wdata[NUM_SRC-1:0] : '0;
  assign w_claim_clr = (rd_en && (w_sel == SEL_CLAIM)) ? w_claim_mask : '0;

  always_comb begin
    w_rdata_next = 32'd0;
    case (w_sel)
      SEL_MTIME:    w_rdata_next = 32'(r_mtime);
      SEL_MTIMECMP: w_rdata_next = 32'(r_mtimecmp);
      SEL_PENDING:  w_rdata_next = 32'(r_pending);
      SEL_ENABLE:   w_rdata_next = 32'(r_enable);
      SEL_CLAIM:    w_rdata_next = 32'(w_claim_id);
      SEL_CTRL:     w_rdata_next = {30'd0, r_ctrl};
      default:      w_rdata_next = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_enable   <= '0;
      r_ctrl     <= 2'b00;
    end else begin
      if (w_wr_mtime)          r_mtime <= wdata[TIMER_WIDTH-1:0];
      else if (r_ctrl[0])      r_mtime <= r_mtime + {{(TIMER_WIDTH-1){1'b0}}, 1'b1};
      if (wr_en && (w_sel == SEL_MTIMECMP)) r_mtimecmp <= wdata[TIMER_WIDTH-1:0];
      if (wr_en && (w_sel == SEL_ENABLE))   r_enable   <= wdata[NUM_SRC-1:0];
      if (wr_en && (w_sel == SEL_CTRL))     r_ctrl     <= wdata[1:0];
    end
  end

  // A fresh edge wins over a W1C or claim clear in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_prev    <= '0;
      r_pending <= '0;
    end else begin
      r_sync1   <= ext_src;
      r_sync2   <= r_sync1;
      r_prev    <= r_sync2;
      r_pending <= (r_pending & ~(w_w1c | w_claim_clr)) | w_edge;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdata <= 32'd0;
      r_mtip  <= 1'b0;
      r_meip  <= 1'b0;
    end else begin
      if (rd_en) r_rdata <= w_rdata_next;
      r_mtip <= w_timer_hit & r_ctrl[1];
      r_meip <= |w_active;
    end
  end

  assign rdata             = r_rdata;
  assign interrupt_occured = {20'd0, r_meip, 3'd0, r_mtip, 7'd0};

endmodule
